cpu8_program_feeder: RTL and testbench
======================================

# cpu8_program_feeder

Instruction sequencer for the 8-bit accumulator CPU. It stores a short program loaded word by word, then streams one instruction at a time onto the CPU's 8-bit instruction input at a fixed pace. It samples the CPU's 8-bit result output while running and reports completion. It sits between the bring-up host interface and the CPU core, so a program can run without a bench driving the instruction bus.

## Interface
- `DEPTH`, 16: program memory words (2..16); `pc` is 4 bits.
- `STEP`, 1: clock cycles each instruction is held on `instr_out` (≥1).
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_valid` in 1: host presents a program word.
- `load_data` in 8: program word, `{opcode[7:4], operand[3:0]}`.
- `load_ready` out 1: word accepted when `load_valid & load_ready`.
- `clear` in 1: empties the program (`prog_len` ← 0).
- `start` in 1: begin a run.
- `stop` in 1: abort a run.
- `instr_out` out 8: drives the CPU instruction input (`in8bit`).
- `cpu_out` in 8: CPU result output (`out8bit`).
- `result` out 8: last sampled `cpu_out`.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `pc` out 4: index of the word currently on `instr_out`.
- `prog_len` out 5: number of loaded words.

## Operation
- States: IDLE, RUN, DRAIN.
- Reset values: state IDLE, `prog_len`=0, `pc`=0, `instr_out`=8'h00 (NOP, opcode 0), `result`=0, `busy`=0, `done`=0, `load_ready`=1.
- **IDLE**
  - `load_ready = (prog_len < DEPTH) & !start & !clear`.
  - An accepted word is written to `mem[prog_len]`, then `prog_len` increments.
  - `clear` sets `prog_len` ← 0. It wins over `load_valid` and `start` in the same cycle.
  - `start` with `prog_len`≠0 moves to RUN with `pc`=0. `start` with `prog_len`=0 is ignored.
- **RUN**
  - `instr_out = mem[pc]`, held `STEP` cycles, then `pc` increments.
  - After word `prog_len-1` completes its `STEP` cycles, go to DRAIN.
  - A word with opcode 4'hF (HALT) is never driven: `instr_out` stays 8'h00 and the block goes to DRAIN on the next edge.
  - `stop` goes to DRAIN on the next edge. The current instruction is cut short.
  - `load_valid`, `clear` and `start` are ignored; `load_ready`=0.
- **DRAIN**
  - Lasts one cycle with `instr_out`=8'h00.
  - Then go to IDLE and pulse `done`.
- `result <= cpu_out` on every edge while in RUN or DRAIN. It holds otherwise, so the final value is the CPU state after the last instruction.
- `busy` = state is RUN or DRAIN.
- Memory contents persist across runs and survive `clear`; only `prog_len` is cleared.
- `rst_n` low mid-run forces all outputs to their reset values immediately. The program is lost because `prog_len`=0.

## Timing
- Edge E0 samples `start`. `busy`=1 and `instr_out`=`mem[0]` from E0.
- Word k is on `instr_out` during cycles `[k·STEP, (k+1)·STEP)` after E0.
- With N words:
  - DRAIN occupies cycle N·STEP.
  - `done`=1 and `busy`=0 in cycle N·STEP+1.
  - Total latency from the `start` edge to `done` is N·STEP+1 cycles.
- `stop` sampled at edge Es: DRAIN in the cycle after Es, `done` one cycle later.
- `done` is never asserted together with `busy`.
- Back-to-back `start` is allowed in the same cycle `done` is high, since the state is IDLE.

## Configuration
- `FEEDER_LOOP_EN` defined:
  - After word `prog_len-1`, `pc` wraps to 0 and RUN continues indefinitely.
  - The run exits only via `stop` or a HALT word, then DRAIN and `done` as usual.
- `FEEDER_LOOP_EN` undefined: the run ends after word `prog_len-1` as described above.

## Test plan
- Load 8'h11, 8'h23, 8'h34, 8'h42, 8'h50 with `STEP`=1, then `start`:
  - `instr_out` is 11, 23, 34, 42, 50 in cycles 0–4, then 00 in cycle 5.
  - `done` pulses in cycle 6, `busy` drops in cycle 6.
  - With the CPU attached, `result` = 8'hF9.
- Same program with `STEP`=3: each word is held exactly 3 cycles, and `done` arrives in cycle 16.
- Load 17 words with `DEPTH`=16: `load_ready` drops after word 16 and `prog_len`=16. Assert `clear` with `load_valid` high: `prog_len`=0 and no write occurs.
- Program 8'h11, 8'hF0, 8'h23: only 11 is driven, then DRAIN, `done` in cycle 3; 23 is never driven.
- Assert `stop` in cycle 2 of the 5-word run: DRAIN in cycle 3, `done` in cycle 4. Then assert `rst_n` low mid-run: `instr_out`=00, `busy`=0 and `prog_len`=0 immediately, with no clock edge.
- With `FEEDER_LOOP_EN` defined, 2-word program: `instr_out` sequence is 11, 23, 11, 23, … until `stop`; `pc` wraps 1→0.

Source files
------------

// File: rtl/cpu8_program_feeder.sv
// cpu8_program_feeder: program store and instruction sequencer for the 8-bit
// accumulator CPU. A host loads up to DEPTH words. A start request then streams
// them onto instr_out, one word per STEP cycles, while cpu_out is sampled into
// result. A one-cycle DRAIN slot with a NOP ends every run, followed by a done
// pulse.
// Optional feature: define FEEDER_LOOP_EN to wrap pc back to word 0 after the
// last word. The run then leaves RUN only on stop or on a HALT word.
module cpu8_program_feeder #(
  parameter int DEPTH = 16,
  parameter int STEP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] instr_out,
  input  logic [7:0] cpu_out,
  output logic [7:0] result,
  output logic       busy,
  output logic       done,
  output logic [3:0] pc,
  output logic [4:0] prog_len
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam int            SW        = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);
  localparam logic [4:0]    DEPTH_LEN = 5'(DEPTH);
  localparam logic [3:0]    OP_HALT   = 4'hF;

  logic [7:0]    mem [DEPTH];
  state_t        state, state_d;
  logic [3:0]    pc_d;
  logic [4:0]    len_d;
  logic [SW-1:0] step_cnt, step_d;
  logic [7:0]    cur_word;
  logic          cur_halt;
  logic          last_word;
  logic          step_end;
  logic          load_fire;

  // Decode the current word and drive the outputs. A HALT word is never driven.
  always_comb begin
    cur_word   = mem[pc];
    cur_halt   = (cur_word[7:4] == OP_HALT);
    last_word  = ({1'b0, pc} == (prog_len - 5'd1));
    step_end   = (step_cnt == STEP_LAST);
    load_ready = (state == S_IDLE) && (prog_len < DEPTH_LEN) && !start && !clear;
    load_fire  = load_valid && load_ready;
    busy       = (state != S_IDLE);
    instr_out  = ((state == S_RUN) && !cur_halt) ? cur_word : 8'h00;
  end

  // Next-state logic for the sequencer, the program counter and the word count.
  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    step_d  = step_cnt;
    len_d   = prog_len;
    case (state)
      S_IDLE: begin
        if (clear) begin
          len_d = 5'd0;
        end else begin
          if (load_fire) len_d = prog_len + 5'd1;
          if (start && (prog_len != 5'd0)) begin
            state_d = S_RUN;
            pc_d    = 4'd0;
            step_d  = '0;
          end
        end
      end
      S_RUN: begin
        if (stop || cur_halt) begin
          state_d = S_DRAIN;
        end else if (step_end) begin
          step_d = '0;
          if (last_word) begin
`ifdef FEEDER_LOOP_EN
            pc_d = 4'd0;
`else
            state_d = S_DRAIN;
`endif
          end else begin
            pc_d = pc + 4'd1;
          end
        end else begin
          step_d = step_cnt + 1'b1;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and control registers. done marks the cycle after DRAIN.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= 4'd0;
      step_cnt <= '0;
      prog_len <= 5'd0;
      result   <= 8'h00;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      step_cnt <= step_d;
      prog_len <= len_d;
      done     <= (state == S_DRAIN);
      if (busy) result <= cpu_out;
    end
  end

  // Program store write port.
  // NOTE: the memory has no reset. prog_len alone decides which words are
  // valid, and stored words survive both clear and reset.
  always_ff @(posedge clk) begin
    if (load_fire) mem[prog_len[3:0]] <= load_data;
  end

endmodule

// File: tb/tb_cpu8_program_feeder.sv
// Testbench for cpu8_program_feeder. A queue-based reference model holds the
// expected instr_out/pc trace of the current run. A negedge compare process
// checks all outputs against that model every cycle. Directed sequences pin
// the exact cycle numbers of the main scenarios.
module tb_cpu8_program_feeder;
  localparam int DEPTH = 16;
  localparam int STEP  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] instr_out;
  logic [7:0] cpu_out = 8'h00;
  logic [7:0] result;
  logic       busy;
  logic       done;
  logic [3:0] pc;
  logic [4:0] prog_len;

  always #5 clk = ~clk;

  cpu8_program_feeder #(.DEPTH(DEPTH), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .clear(clear), .start(start), .stop(stop),
    .instr_out(instr_out), .cpu_out(cpu_out), .result(result), .busy(busy),
    .done(done), .pc(pc), .prog_len(prog_len)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_q holds the remaining {pc, instr_out} pairs of the current run. Its front
  // entry is the one on the bus this cycle.
  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] ins;
  } ent_t;

  logic [7:0] m_mem [DEPTH];
  int         m_len = 0;
  int         m_mode = 0;   // 0 idle, 1 run, 2 drain
  int         old_mode;
  logic       m_done = 1'b0;
  logic [7:0] m_result = 8'h00;
  logic       m_halted = 1'b0;
  ent_t       m_q[$];

  task build_queue();
    m_q.delete();
    m_halted = 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (m_mem[k][7:4] == 4'hF) begin
        m_q.push_back({4'(k), 8'h00});
        m_halted = 1'b1;
        break;
      end
      for (int s = 0; s < STEP; s++) m_q.push_back({4'(k), m_mem[k]});
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_len = 0; m_done = 1'b0; m_result = 8'h00;
      m_q.delete();
    end else begin
      old_mode = m_mode;
      m_done = (old_mode == 2);
      if (old_mode != 0) m_result = cpu_out;
      case (old_mode)
        0: begin
          if (clear) m_len = 0;
          else begin
            if (load_valid && m_len < DEPTH && !start) begin
              m_mem[m_len] = load_data;
              m_len++;
            end
            if (start && m_len != 0) begin
              build_queue();
              m_mode = 1;
            end
          end
        end
        1: begin
          if (stop) begin
            m_q.delete();
            m_mode = 2;
          end else begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
`ifdef FEEDER_LOOP_EN
              if (m_halted) m_mode = 2; else build_queue();
`else
              m_mode = 2;
`endif
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("done", 32'(done), 32'(m_done));
      check("prog_len", 32'(prog_len), 32'(m_len));
      check("result", 32'(result), 32'(m_result));
      check("load_ready", 32'(load_ready), 32'(m_mode == 0 && m_len < DEPTH && !start && !clear));
      if (m_mode == 1) begin
        check("instr_out", 32'(instr_out), 32'(m_q[0].ins));
        check("pc", 32'(pc), 32'(m_q[0].pc));
      end else begin
        check("instr_out_idle", 32'(instr_out), 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] trace [64];

  task automatic tick();
    @(posedge clk);
    #1;
    cpu_out = 8'($urandom);
  endtask

  task automatic load_word(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records instr_out per cycle after the start edge. Returns the cycle in
  // which done is high, or -1 if done never comes within the budget.
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int c = 0; c < budget; c++) begin
      trace[c] = instr_out;
      if (done) begin
        cyc = c;
        break;
      end
      tick();
    end
  endtask

  int cyc;

  initial begin
    // Reset values, checked while reset is held.
    #3;
    check("rst_instr", 32'(instr_out), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_prog_len", 32'(prog_len), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_load_ready", 32'(load_ready), 32'h1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

`ifndef FEEDER_LOOP_EN
    // Five-word program: each word is held STEP=3 cycles, and done comes in cycle 16.
    load_word(8'h11); load_word(8'h23); load_word(8'h34); load_word(8'h42); load_word(8'h50);
    check("len5", 32'(prog_len), 32'd5);
    start_run();
    wait_done(60, cyc);
    check("run_done_cycle", 32'(cyc), 32'd16);
    check("run_c0", 32'(trace[0]), 32'h11);
    check("run_c2", 32'(trace[2]), 32'h11);
    check("run_c3", 32'(trace[3]), 32'h23);
    check("run_c14", 32'(trace[14]), 32'h50);
    check("run_c15_drain", 32'(trace[15]), 32'h00);
    check("run_done_busy", 32'(busy), 32'h0);

    // stop sampled at the edge ending cycle 2: DRAIN in cycle 3, done in cycle 4.
    tick();
    start_run();
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_c3_busy", 32'(busy), 32'h1);
    check("stop_c3_instr", 32'(instr_out), 32'h00);
    tick();
    check("stop_c4_done", 32'(done), 32'h1);
    check("stop_c4_busy", 32'(busy), 32'h0);
`else
    // Loop mode: a two-word program wraps until stop.
    load_word(8'h11); load_word(8'h23);
    start_run();
    for (int c = 0; c < 8; c++) begin
      trace[c] = instr_out;
      tick();
    end
    check("loop_c0", 32'(trace[0]), 32'h11);
    check("loop_c3", 32'(trace[3]), 32'h23);
    check("loop_c6", 32'(trace[6]), 32'h11);
    check("loop_c7", 32'(trace[7]), 32'h11);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("loop_stop_done", 32'(done), 32'h1);
`endif

    // HALT program: only 11 is driven, then a NOP slot, DRAIN, and done in cycle 5.
    tick();
    do_clear();
    load_word(8'h11); load_word(8'hF0); load_word(8'h23);
    start_run();
    wait_done(60, cyc);
    check("halt_done_cycle", 32'(cyc), 32'd5);
    check("halt_c2", 32'(trace[2]), 32'h11);
    check("halt_c3", 32'(trace[3]), 32'h00);
    check("halt_c4", 32'(trace[4]), 32'h00);

    // Overfill: the 17th word is refused, and clear wins over load_valid.
    do_clear();
    for (int i = 0; i < 17; i++) load_word({4'($urandom_range(0, 14)), 4'($urandom)});
    load_valid = 1'b1;
    #1;
    check("full_len", 32'(prog_len), 32'd16);
    check("full_ready", 32'(load_ready), 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load_valid = 1'b0;
    check("clear_len", 32'(prog_len), 32'd0);

    // Asynchronous reset in the middle of a run.
    load_word(8'h11); load_word(8'h23); load_word(8'h34);
    start_run();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_instr", 32'(instr_out), 32'h00);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_prog_len", 32'(prog_len), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Randomized traffic, checked against the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      load_valid = ($urandom_range(0, 9) < 4);
      load_data  = 8'($urandom);
      clear      = ($urandom_range(0, 99) < 3);
      start      = ($urandom_range(0, 9) == 0);
      stop       = ($urandom_range(0, 99) < 3);
      tick();
    end
    load_valid = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
